// File: rtl/imem_loader.sv
// ============================================================================
// Module      : imem_loader
// Description : Byte-stream program loader for the CPU instruction memory.
//               Accepts a little-endian stream (16-bit word count, then the
//               words LS byte first), writes each word to the im write port
//               and releases the core (cpu_run) once the image is complete.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader #(
    parameter int DATA_WIDTH = 32,  // multiple of 8
    parameter int ADDR_WIDTH = 8    // im word-address width, at most 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  im_we,
    output logic [ADDR_WIDTH-1:0] im_addr,
    output logic [DATA_WIDTH-1:0] im_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  cpu_run
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [BCW-1:0] LAST_LANE = BCW'(BYTES - 1);
    // Capacity in words; one extra bit so that N == 2**ADDR_WIDTH is representable.
    localparam logic [16:0] CAPACITY = 17'(1) << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    state_t                  state_q;
    logic [15:0]             len_q;
    logic [BCW-1:0]          byte_cnt_q;
    logic [15:0]             word_cnt_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    im_we_q;
    logic [ADDR_WIDTH-1:0]   im_addr_q;
    logic [DATA_WIDTH-1:0]   im_wdata_q;

    logic [DATA_WIDTH-1:0]   word_d;
    logic [15:0]             len_d;

    // Word as it will look once the incoming byte fills the top lane, and the full header count.
    always_comb begin
        word_d                     = data_q;
        word_d[DATA_WIDTH-1 -: 8]  = in_data;
        len_d                      = {in_data, len_q[7:0]};
    end

    // Status outputs are pure decodes of the state register, so they never glitch.
    assign in_ready = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) || (state_q == S_DATA);
    assign busy     = in_ready;
    assign done     = (state_q == S_DONE);
    assign cpu_run  = (state_q == S_DONE);
    assign err      = (state_q == S_ERR);
    assign im_we    = im_we_q;
    assign im_addr  = im_addr_q;
    assign im_wdata = im_wdata_q;

    // Loader FSM: header parse, byte assembly, one-cycle-latency word writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            im_we_q    <= 1'b0;
            im_addr_q  <= '0;
            im_wdata_q <= '0;
        end else begin
            // Write strobe is a single-cycle pulse; a pulse already issued completes
            // even if start arrives, because it is only ever cleared here.
            im_we_q <= 1'b0;
            if (start) begin
                // Start wins over any byte presented in the same cycle (the byte is dropped).
                state_q    <= S_LEN_LO;
                len_q      <= '0;
                byte_cnt_q <= '0;
                word_cnt_q <= '0;
                addr_q     <= '0;
                data_q     <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        state_q <= S_IDLE;
                    end
                    S_LEN_LO: begin
                        if (in_valid) begin
                            len_q[7:0] <= in_data;
                            state_q    <= S_LEN_HI;
                        end
                    end
                    S_LEN_HI: begin
                        if (in_valid) begin
                            len_q      <= len_d;
                            byte_cnt_q <= '0;
                            word_cnt_q <= '0;
                            addr_q     <= '0;
                            if (len_d == 16'd0) begin
                                state_q <= S_DONE;
                            end else if ({1'b0, len_d} > CAPACITY) begin
                                state_q <= S_ERR;
                            end else begin
                                state_q <= S_DATA;
                            end
                        end
                    end
                    S_DATA: begin
                        if (in_valid) begin
                            if (byte_cnt_q == LAST_LANE) begin
                                im_we_q    <= 1'b1;
                                im_addr_q  <= addr_q;
                                im_wdata_q <= word_d;
                                // Wraps to 0 after a full-capacity image; harmless since we stop.
                                addr_q     <= addr_q + ADDR_WIDTH'(1);
                                byte_cnt_q <= '0;
                                word_cnt_q <= word_cnt_q + 16'd1;
                                if (word_cnt_q == (len_q - 16'd1)) begin
                                    state_q <= S_DONE;
                                end
                            end else begin
                                data_q[{byte_cnt_q, 3'b000} +: 8] <= in_data;
                                byte_cnt_q <= byte_cnt_q + BCW'(1);
                            end
                        end
                    end
                    S_DONE: begin
                        state_q <= S_DONE;
                    end
                    S_ERR: begin
                        state_q <= S_ERR;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire
